// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the MEM-stage
// MemRead/MemWrite interface. Each load or store spends LATENCY cycles in
// BUSY, completes in a single DONE cycle, and holds MemStall high while the
// access is outstanding so the pipeline stays frozen.
// Optional build macro: DMEM_ALIGN_CHECK_EN. When it is defined, a misaligned
// request skips BUSY entirely and completes with MemError set.
module dmem_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemStall,
    output logic              MemDone,
    output logic              MemError
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType                state;
    stateType                nextState;
    logic [3:0]              counter;
    logic                    pendingRead;
    logic [DEPTH_LOG2-1:0]   pendingIndex;
    logic [DATA_W-1:0]       pendingData;
    logic                    req;
    logic                    acceptReq;
    logic                    doAccess;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic                    unusedAddrBits;

`ifdef DMEM_ALIGN_CHECK_EN
    logic                    misaligned;
    logic                    misalignReq;

    assign misaligned = (Address[1:0] != 2'b00);
`endif

    // A simultaneous read and write request is treated as a read.
    assign req = MemRead | MemWrite;

    // Address bits above the word index alias; the byte offset is dropped.
    assign unusedAddrBits = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

    // State register for the request / busy / done sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; MemStall is combinational so a new request freezes the pipe at once.
    always_comb begin
        nextState = state;
        MemStall  = 1'b0;
        acceptReq = 1'b0;
        doAccess  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        misalignReq = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req) begin
                    MemStall = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
                    if (misaligned) begin
                        misalignReq = 1'b1;
                        nextState   = DONE;
                    end else begin
                        acceptReq = 1'b1;
                        nextState = BUSY;
                    end
`else
                    acceptReq = 1'b1;
                    nextState = BUSY;
`endif
                end
            end
            BUSY: begin
                MemStall = 1'b1;
                if (counter == 4'd0) begin
                    doAccess  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Latch the request, run the latency countdown, and register the load result and completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter      <= 4'd0;
            pendingRead  <= 1'b0;
            pendingIndex <= '0;
            pendingData  <= '0;
            ReadData     <= '0;
            MemDone      <= 1'b0;
        end else begin
            MemDone <= (nextState == DONE);
            if (acceptReq) begin
                pendingRead  <= MemRead;
                pendingIndex <= Address[DEPTH_LOG2+1:2];
                pendingData  <= WriteData;
                counter      <= 4'(LATENCY - 1);
            end else if ((state == BUSY) && (counter != 4'd0)) begin
                counter <= counter - 4'd1;
            end
            if (doAccess && pendingRead) begin
                ReadData <= mem[pendingIndex];
            end
        end
    end

    // Array write port; a store caught by reset at its access edge is dropped.
    always_ff @(posedge clock) begin
        if (doAccess && !pendingRead && !reset) begin
            mem[pendingIndex] <= pendingData;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Error flag is raised only in the DONE cycle of a rejected misaligned request.
    always_ff @(posedge clock) begin
        if (reset) begin
            MemError <= 1'b0;
        end else begin
            MemError <= misalignReq;
        end
    end
`else
    assign MemError = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized load/store traffic,
// checked every cycle against a timeline model of the responder.
module tb_dmem_responder;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              MemStall;
    logic              MemDone;
    logic              MemError;

    int vectors     = 0;
    int miscompares = 0;

    dmem_responder #(
        .DATA_W(DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY(LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Address(Address),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .MemStall(MemStall),
        .MemDone(MemDone),
        .MemError(MemError)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    // Model state: the op in flight, how many cycles since it was accepted, and the expected array.
    bit                    modelValid = 1'b0;
    bit                    mActive    = 1'b0;
    int                    mK         = 0;
    bit                    mRead      = 1'b0;
    bit                    mMis       = 1'b0;
    logic [DEPTH_LOG2-1:0] mIdx       = '0;
    logic [DATA_W-1:0]     mData      = '0;
    logic [DATA_W-1:0]     expRD      = '0;
    logic [DATA_W-1:0]     mMem [int];
    int                    doneK;
    logic                  mReq;
    logic                  eStall;
    logic                  eDone;
    logic                  eErr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Every cycle: compare outputs against the model, then advance the model across the coming edge.
    always @(negedge clock) begin
        mReq = MemRead | MemWrite;
        if (modelValid) begin
            if (!mActive) begin
                eStall = mReq;
                eDone  = 1'b0;
                eErr   = 1'b0;
            end else begin
                doneK  = mMis ? 1 : LATENCY + 1;
                eStall = (mK < doneK);
                eDone  = (mK == doneK);
                eErr   = eDone & mMis;
            end
            checkOutput("MemStall", {31'b0, MemStall}, {31'b0, eStall});
            checkOutput("MemDone", {31'b0, MemDone}, {31'b0, eDone});
            checkOutput("MemError", {31'b0, MemError}, {31'b0, eErr});
            checkOutput("ReadData", ReadData, expRD);
        end
        if (reset) begin
            modelValid = 1'b1;
            mActive    = 1'b0;
            expRD      = '0;
        end else if (modelValid) begin
            if (!mActive) begin
                if (mReq) begin
                    mActive = 1'b1;
                    mK      = 1;
                    mRead   = MemRead;
                    mIdx    = Address[DEPTH_LOG2+1:2];
                    mData   = WriteData;
                    mMis    = ALIGN_ON && (Address[1:0] != 2'b00);
                end
            end else begin
                doneK = mMis ? 1 : LATENCY + 1;
                if (!mMis && mK == LATENCY) begin
                    if (mRead) expRD = mMem[int'(mIdx)];
                    else       mMem[int'(mIdx)] = mData;
                end
                if (mK == doneK) mActive = 1'b0;
                else             mK++;
            end
        end
    end

    // Present one request and hold it, as a stalled pipeline would, until its DONE cycle has passed.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, output int stalls, output int dones,
                                 output logic [31:0] rdata, output logic err);
        bit got;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = data;
        stalls = 0;
        dones  = 0;
        rdata  = '0;
        err    = 1'b0;
        got    = 1'b0;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge clock);
            if (MemStall === 1'b1) stalls++;
            if (MemDone === 1'b1) begin
                dones++;
                rdata = ReadData;
                err   = MemError;
                got   = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        if (!got) checkOutput("opTimeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random traffic.
    initial begin
        int               st;
        int               dn;
        int               st2;
        int               dn2;
        logic [31:0]      rdv;
        logic [31:0]      rdv2;
        logic             er;
        logic [31:0]      misExpRd;
        int               misExpStall;
        int               kind;
        logic [31:0]      addr;

        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("resetReadData", ReadData, 32'h0);
        checkOutput("resetMemDone", {31'b0, MemDone}, 32'h0);
        @(posedge clock);
        #1;

        // Store then load the same word.
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, st, dn, rdv, er);
        checkOutput("storeStalls", st, 32'd3);
        checkOutput("storeDones", dn, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, st, dn, rdv, er);
        checkOutput("loadStalls", st, 32'd3);
        checkOutput("loadData", rdv, 32'hDEADBEEF);

        // Back-to-back loads with requests held through DONE.
        applyStimulus(1'b0, 1'b1, 32'h44, 32'hCAFEF00D, st, dn, rdv, er);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, st, dn, rdv, er);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, st2, dn2, rdv2, er);
        checkOutput("b2bFirstData", rdv, 32'hDEADBEEF);
        checkOutput("b2bSecondData", rdv2, 32'hCAFEF00D);
        checkOutput("b2bDoneTotal", dn + dn2, 32'd2);
        checkOutput("b2bSecondStalls", st2, 32'd3);
        idleCycles(2);

        // Reset during the first BUSY cycle of a store discards it.
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hAAAAAAAA, st, dn, rdv, er);
        idleCycles(1);
        MemWrite  = 1'b1;
        Address   = 32'h10;
        WriteData = 32'h12345678;
        @(posedge clock);
        #1;
        reset    = 1'b1;
        MemWrite = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("postResetReadData", ReadData, 32'h0);
        checkOutput("postResetStall", {31'b0, MemStall}, 32'h0);
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, st, dn, rdv, er);
        checkOutput("discardedStore", rdv, 32'hAAAAAAAA);

        // Address aliasing above the word index.
        applyStimulus(1'b0, 1'b1, 32'h0000_0008, 32'h11, st, dn, rdv, er);
        applyStimulus(1'b1, 1'b0, 32'h0000_1008, 32'h0, st, dn, rdv, er);
        checkOutput("aliasLoad", rdv, 32'h11);

        // Read and write together behave as a read.
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h5, st, dn, rdv, er);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h9, st, dn, rdv, er);
        checkOutput("bothHighData", rdv, 32'h5);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, st, dn, rdv, er);
        checkOutput("bothHighNoWrite", rdv, 32'h5);

        // Misaligned load at 0x42 after a load that leaves ReadData at 0xCAFEF00D.
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, st, dn, rdv, er);
`ifdef DMEM_ALIGN_CHECK_EN
        misExpRd    = 32'hCAFEF00D;
        misExpStall = 1;
`else
        misExpRd    = 32'hDEADBEEF;
        misExpStall = 3;
`endif
        applyStimulus(1'b1, 1'b0, 32'h42, 32'h0, st, dn, rdv, er);
        checkOutput("misalignStalls", st, misExpStall);
        checkOutput("misalignData", rdv, misExpRd);
        checkOutput("misalignError", {31'b0, er}, {31'b0, ALIGN_ON});
        idleCycles(1);

        // Random traffic over a small initialized window, with aliased high bits and odd offsets.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, st, dn, rdv, er);
        end
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 3);
            addr = (32'($urandom_range(0, 15)) << 12) | (32'h100 + 32'($urandom_range(0, 15) * 4));
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(kind <= 1 || kind == 3, kind >= 2, addr, $urandom, st, dn, rdv, er);
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
        end
        idleCycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
